// File: rtl/apb_reg_slave_if.sv
// APB bus bundle for apb_reg_slave: the master drives the request, the slave returns prdata.
interface apb_reg_slave_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata);
endinterface

// File: rtl/apb_reg_slave.sv
// APB register slave with 8 RW regs, an RO status word and an RO write counter; reads are captured at the setup edge, and writes commit at the access edge.
// There are no wait states or backpressure. Defining APB_SLV_PROTO_CHECK_EN adds the sticky proto_err output.
module apb_reg_slave #(
  parameter logic [31:0] REG_RST_VAL = 32'h0000_0000
) (
  input  logic            pclk,
  input  logic            presetn,
  apb_reg_slave_if.slave  apb,
  input  logic [31:0]     status_in,
  output logic [255:0]    reg_q,
  output logic [7:0]      wr_strobe
`ifdef APB_SLV_PROTO_CHECK_EN
  ,
  output logic            proto_err
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e           state_q;
  logic [7:0][31:0] regs_q;
  logic [31:0]      prdata_q;
  logic [31:0]      wr_cnt_q;
  logic [31:0]      wr_cnt_d;
  logic [7:0]       wr_strobe_q;
  logic [3:0]       idx;
  logic             mapped;
  logic             setup_go;
  logic             access_go;
  logic             rw_commit;
  logic             rd_capture;
  logic [31:0]      rd_val;
  logic             unused_paddr_lsb;

  assign idx              = apb.paddr[5:2];
  assign mapped           = (apb.paddr[31:6] == 26'd0);
  assign setup_go         = apb.psel && !apb.penable;
  assign access_go        = apb.psel && apb.penable;
  assign unused_paddr_lsb = ^apb.paddr[1:0];

  // state_q lags the bus by one phase: it reads SETUP while the bus is in its access cycle
  assign rw_commit  = (state_q == SETUP) && access_go && apb.pwrite && mapped && !idx[3];
  assign rd_capture = (state_q != SETUP) && setup_go && !apb.pwrite;
  assign wr_cnt_d   = wr_cnt_q + {31'd0, rw_commit};

  always_comb begin
    rd_val = 32'd0;
    if (mapped) begin
      if (!idx[3])         rd_val = regs_q[idx[2:0]];
      else if (idx == 4'd8) rd_val = status_in;
      else if (idx == 4'd9) rd_val = wr_cnt_q;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= IDLE;
      regs_q      <= {8{REG_RST_VAL}};
      prdata_q    <= 32'd0;
      wr_cnt_q    <= 32'd0;
      wr_strobe_q <= 8'd0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_strobe_q <= 8'd0;
      if (rw_commit) begin
        regs_q[idx[2:0]]      <= apb.pwdata;
        wr_strobe_q[idx[2:0]] <= 1'b1;
      end
      if (rd_capture) prdata_q <= rd_val;
      case (state_q)
        IDLE:    state_q <= setup_go  ? SETUP  : IDLE;
        SETUP:   state_q <= access_go ? ACCESS : IDLE;
        ACCESS:  state_q <= setup_go  ? SETUP  : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign apb.prdata = prdata_q;
  assign reg_q      = regs_q;
  assign wr_strobe  = wr_strobe_q;

`ifdef APB_SLV_PROTO_CHECK_EN
  logic [31:0] setup_addr_q;
  logic [31:0] setup_wdata_q;
  logic        setup_write_q;
  logic        proto_err_q;
  logic        req_changed;

  assign req_changed = (apb.paddr != setup_addr_q) || (apb.pwrite != setup_write_q) ||
                       (apb.pwdata != setup_wdata_q);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      setup_addr_q  <= 32'd0;
      setup_wdata_q <= 32'd0;
      setup_write_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      if ((state_q != SETUP) && setup_go) begin
        setup_addr_q  <= apb.paddr;
        setup_wdata_q <= apb.pwdata;
        setup_write_q <= apb.pwrite;
      end
      if (((state_q != SETUP) && apb.penable) || ((state_q == SETUP) && access_go && req_changed))
        proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed and randomized bench for apb_reg_slave against a simple array model of the register map.
module tb_apb_reg_slave;
  localparam logic [31:0] RST_VAL = 32'h1357_9BDF;

  logic         pclk = 1'b0;
  logic         presetn;
  logic [31:0]  status_in;
  logic [255:0] reg_q;
  logic [7:0]   wr_strobe;
`ifdef APB_SLV_PROTO_CHECK_EN
  logic         proto_err;
`endif

  apb_reg_slave_if bus ();

  apb_reg_slave #(.REG_RST_VAL(RST_VAL)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (bus),
    .status_in (status_in),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe)
`ifdef APB_SLV_PROTO_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  always #5 pclk = ~pclk;

  logic [31:0] m_regs [8];
  logic [31:0] m_cnt;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned w;
    if (a >= 32'd64) return 32'd0;
    w = a / 4;
    if (w < 8)  return m_regs[w];
    if (w == 8) return status_in;
    if (w == 9) return m_cnt;
    return 32'd0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = RST_VAL;
    m_cnt = 32'd0;
  endtask

  // leaves the bus in its access cycle; the caller must drive the next phase immediately
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    rd = bus.prdata;
    @(posedge pclk); #1;
  endtask

  task automatic idle(input int n);
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] rd;
    logic [7:0]  exp_strb;
    int unsigned w;
    exp_strb = 8'd0;
    w = a / 4;
    if (a < 32'd64 && w < 8) begin
      m_regs[w] = d;
      m_cnt     = m_cnt + 32'd1;
      exp_strb  = 8'(1 << w);
    end
    xfer(1'b1, a, d, rd);
    check($sformatf("%s strobe @%h", tag, a), {24'd0, wr_strobe}, {24'd0, exp_strb});
    if (exp_strb != 8'd0)
      check($sformatf("%s reg_q[%0d]", tag, w), reg_q[32*w +: 32], d);
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    exp = m_read(a);
    xfer(1'b0, a, 32'd0, rd);
    check($sformatf("%s prdata @%h", tag, a), rd, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] rd;

    presetn = 1'b0; status_in = 32'd0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'd0; bus.pwdata = 32'd0;
    m_reset();
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;

    for (int i = 0; i < 8; i++) check($sformatf("reset reg_q[%0d]", i), reg_q[32*i +: 32], RST_VAL);
    check("reset prdata", bus.prdata, 32'd0);
    check("reset strobe", {24'd0, wr_strobe}, 32'd0);
`ifdef APB_SLV_PROTO_CHECK_EN
    check("reset proto_err", {31'd0, proto_err}, 32'd0);
`endif

    do_write(32'h04, 32'hDEAD_BEEF, "cov_wr4");
    check("cov_wr4 reg1", reg_q[63:32], 32'hDEAD_BEEF);
    check("cov_wr4 strobe", {24'd0, wr_strobe}, 32'h02);
    idle(1);
    check("cov_wr4 strobe end", {24'd0, wr_strobe}, 32'h00);
    xfer(1'b0, 32'h24, 32'd0, rd);
    check("cov_wr4 counter", rd, 32'd1);

    do_write(32'h08, 32'h5, "b2b_wr");
    xfer(1'b0, 32'h08, 32'd0, rd);
    check("b2b read", rd, 32'h5);
    idle(1);

    status_in = 32'hA5A5_0001;
    xfer(1'b0, 32'h20, 32'd0, rd);
    check("status read", rd, 32'hA5A5_0001);
    do_write(32'h20, 32'h1111_2222, "ro_wr");
    check("ro_wr strobe", {24'd0, wr_strobe}, 32'd0);
    xfer(1'b0, 32'h24, 32'd0, rd);
    check("ro_wr counter", rd, 32'd2);
    idle(1);

    do_read(32'h40, "unmapped");
    idle(1);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1; bus.paddr = 32'h0; bus.pwdata = 32'hFFFF_0000;
    @(posedge pclk); #1;
    idle(1);
    check("no-setup strobe", {24'd0, wr_strobe}, 32'd0);
    check("no-setup reg0", reg_q[31:0], RST_VAL);
`ifdef APB_SLV_PROTO_CHECK_EN
    check("no-setup proto_err", {31'd0, proto_err}, 32'd1);
`endif

    do_write(32'h00, 32'h0BAD_F00D, "pre_rst");
    do_read(32'h00, "pre_rst");
    idle(1);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'h0; bus.pwdata = 32'hCAFE_0000;
    @(posedge pclk); #1;
    bus.penable = 1'b1; presetn = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1; bus.psel = 1'b0; bus.penable = 1'b0;
    m_reset();
    check("rst_wr reg0", reg_q[31:0], RST_VAL);
    check("rst_wr prdata", bus.prdata, 32'd0);
    check("rst_wr strobe", {24'd0, wr_strobe}, 32'd0);
`ifdef APB_SLV_PROTO_CHECK_EN
    check("rst_wr proto_err", {31'd0, proto_err}, 32'd0);
`endif
    do_read(32'h24, "rst_wr counter");
    idle(1);

    force dut.wr_cnt_d = 32'hFFFF_FFFF;
    @(posedge pclk); #1;
    release dut.wr_cnt_d;
    m_cnt = 32'hFFFF_FFFF;
    do_read(32'h24, "wrap pre");
    do_write(32'h1C, 32'h7777_8888, "wrap");
    idle(1);
    xfer(1'b0, 32'h24, 32'd0, rd);
    check("wrap counter", rd, 32'd0);
    m_cnt = 32'd0;
    idle(1);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom();
        a[6] = 1'b1;
      end else begin
        a = 32'($urandom_range(0, 63));
      end
      status_in = $urandom();
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom(), "rand");
      else                           do_read(a, "rand");
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    for (int i = 0; i < 8; i++) check($sformatf("final reg_q[%0d]", i), reg_q[32*i +: 32], m_regs[i]);
    do_read(32'h24, "final counter");
    idle(1);
`ifdef APB_SLV_PROTO_CHECK_EN
    check("final proto_err", {31'd0, proto_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter: REG_RST_VAL, 32'h0000_0000, reset value of every RW register.
REQ-002 SHALL have port: pclk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: presetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: paddr  input  32  APB byte address.
REQ-005 SHALL have port: psel  input  1  APB select.
REQ-006 SHALL have port: penable  input  1  APB enable (access phase).
REQ-007 SHALL have port: pwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: pwdata  input  32  write data.
REQ-009 SHALL have port: prdata  output  32  read data, registered.
REQ-010 SHALL have port: status_in  input  32  hardware status word, read-only via APB.
REQ-011 SHALL have port: reg_q  output  256  RW registers 0..7 flattened; reg N at bits [32N+31:32N].
REQ-012 SHALL have port: wr_strobe  output  8  one-cycle pulse per RW register on write commit.
REQ-013 SHALL have no pready/pslverr; every transfer completes with zero wait states.

Function
REQ-014 SHALL run an FSM with states IDLE, SETUP, ACCESS, sampled per rising edge.
- IDLE->SETUP on psel=1, penable=0; otherwise stay IDLE.
- SETUP->ACCESS on psel=1, penable=1; otherwise ->IDLE with no transfer.
- ACCESS->SETUP on psel=1, penable=0 (back-to-back); otherwise ->IDLE.
REQ-015 SHALL ignore penable=1 sampled in IDLE or ACCESS (no write, no read capture).
REQ-016 SHALL decode index = paddr[5:2]; paddr[1:0] ignored; any paddr[31:6] != 0 is unmapped.
REQ-017 SHALL map: index 0-7 RW reg; 8 status_in (RO); 9 write counter (RO); 10-15 and unmapped read 0.
REQ-018 SHALL commit a write at the edge that samples SETUP->ACCESS with pwrite=1; write data = pwdata at that edge.
REQ-019 SHALL pulse wr_strobe[index] high for exactly the cycle after a commit to index 0-7; else 0.
REQ-020 SHALL ignore writes to index 8-15 and unmapped addresses (no strobe, no counter increment).
REQ-021 SHALL load prdata at the edge sampling IDLE/ACCESS->SETUP with pwrite=0, so prdata is valid throughout the access cycle.
REQ-022 SHALL hold prdata unchanged until the next read capture.
REQ-023 SHALL read status_in as sampled at the capture edge.
REQ-024 SHALL keep a 32-bit write counter incremented on each committed RW write, wrapping FFFF_FFFF->0.
REQ-025 SHALL return the already-updated value for a read whose setup directly follows a write access to the same register.
REQ-026 SHALL drive reg_q combinationally from the register flops (no extra latency).

Reset
REQ-027 SHALL, on presetn=0 at a rising edge: FSM->IDLE; RW regs->REG_RST_VAL; prdata, counter, wr_strobe->0.
REQ-028 SHALL abort any in-flight transfer on reset; a write whose access edge coincides with presetn=0 is not committed.

Configuration
REQ-029 SHALL, with APB_SLV_PROTO_CHECK_EN defined, add output proto_err (1 bit, sticky, reset 0).
- proto_err sets on: penable=1 sampled in IDLE or ACCESS; or paddr/pwrite/pwdata in ACCESS differing from the value captured in SETUP.
- proto_err clears only on reset.
REQ-030 SHALL, without APB_SLV_PROTO_CHECK_EN, omit the proto_err port and its logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to paddr 0x04 -> reg_q[63:32]=DEADBEEF, wr_strobe=8'h02 for 1 cycle, counter=1.
REQ-032 SHALL cover: back-to-back write 0x5 then read, both at 0x08 -> prdata=0x5 in the read access cycle.
REQ-033 SHALL cover: status_in=0xA5A5_0001, read 0x20 -> prdata=A5A50001; write 0x20 -> no strobe, counter unchanged.
REQ-034 SHALL cover: read 0x40 (unmapped) -> prdata=0; penable=1 without setup -> no write; proto_err=1 when macro defined.
REQ-035 SHALL cover: presetn=0 during a write access to 0x00 -> reg_q[31:0]=REG_RST_VAL, prdata=0, FSM=IDLE.
REQ-036 SHALL cover: counter preloaded by 2^32-1 writes (force) plus one write -> counter reads 0.
